// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined data memory: latency limits, lane helpers
// and the response metadata that travels next to the read data.
package dmem_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    localparam int DEFAULT_DATA_W = 32;
    localparam int BYTES          = DEFAULT_DATA_W / 8;
    localparam int OFF_W          = $clog2(BYTES);

    // Response bundle is {rdata, err, we}; the data part is sized by the instance.
    typedef struct packed {
        logic err;
        logic we;
    } resp_meta_t;

    localparam int RESP_META_W = $bits(resp_meta_t);

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_w_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic bit rd_lat_legal(input int rd_lat);
        return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/dmem_pipe_resp_fifo.sv
// Synchronous FIFO for buffered memory responses; storage is reset so an empty
// FIFO always presents zeros on its output.
module resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when an entry leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : store[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (do_push) begin
                store[wr_ptr] <= din;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined data memory: valid/ready requests with byte masks, fixed read latency
// and an in-order response FIFO sized so the pipeline itself never has to stall.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int unsigned             DATA_W    = 32,
    parameter int unsigned             ADDR_W    = 32,
    parameter int unsigned             DEPTH     = 16384,
    parameter logic [ADDR_W-1:0]       BASE_ADDR = '0,
    parameter int                      RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [DATA_W/8-1:0]    req_wmask,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_err,
    output logic                   resp_we
);

    localparam int                N_BYTES = bytes_of(DATA_W);
    localparam int                N_OFF_W = off_w_of(DATA_W);
    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                FIFO_D  = RD_LAT + 2;
    localparam int                CNT_W   = $clog2(FIFO_D + 1);
    localparam int                RESP_W  = DATA_W + RESP_META_W;
    localparam longint unsigned   LIMIT   = 64'(DEPTH) * 64'(N_BYTES);

    if (!rd_lat_legal(RD_LAT) || (DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_params
        $error("dmem_pipe: RD_LAT must be 1..4 and DATA_W a nonzero multiple of 8");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  word_idx;
    logic              err_req;
    logic              accept;

    logic              run_q;
    logic [CNT_W-1:0]  outstanding_q;

    logic [RD_LAT-1:0] st_valid;
    logic [DATA_W-1:0] st_data [RD_LAT];
    resp_meta_t        st_meta [RD_LAT];

    logic [RESP_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop;
    resp_meta_t        out_meta;

    assign off      = req_addr - BASE_ADDR;
    assign word_idx = IDX_W'(off >> N_OFF_W);
    assign err_req  = ((off & ADDR_W'(N_BYTES - 1)) != '0)
                   || (64'(off) >= LIMIT)
                   || (req_addr < BASE_ADDR);

    assign req_ready = run_q && (outstanding_q < CNT_W'(FIFO_D));
    assign accept    = req_valid && req_ready;
    assign pop       = resp_valid && resp_ready;

    // The array has no reset so its contents survive a pipeline flush.
    always_ff @(posedge clk) begin
        if (accept && req_we && !err_req) begin
            for (int b = 0; b < N_BYTES; b++) begin
                if (req_wmask[b]) begin
                    mem[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                st_data[i] <= '0;
                st_meta[i] <= '0;
            end
        end else begin
            st_valid[0] <= accept;
            st_meta[0]  <= '{err: err_req, we: req_we};
            st_data[0]  <= (accept && !req_we && !err_req) ? mem[word_idx] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_meta[i]  <= st_meta[i-1];
                st_data[i]  <= st_data[i-1];
            end
        end
    end

    // Outstanding covers the pipeline plus FIFO, so admission can never overflow the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            outstanding_q <= '0;
        end else begin
            run_q         <= 1'b1;
            outstanding_q <= outstanding_q + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (FIFO_D)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (st_valid[RD_LAT-1]),
        .din   ({st_data[RD_LAT-1], st_meta[RD_LAT-1]}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign resp_valid = !fifo_empty;
    assign resp_rdata = fifo_dout[RESP_W-1 -: DATA_W];
    assign out_meta   = resp_meta_t'(fifo_dout[RESP_META_W-1:0]);
    assign resp_err   = out_meta.err;
    assign resp_we    = out_meta.we;

    a_outstanding_consistent : assert property (@(posedge clk) disable iff (!rst_n)
        (outstanding_q == CNT_W'($countones(st_valid)) + fifo_count) && !(fifo_full && st_valid[RD_LAT-1] && !pop));

endmodule

// File: tb/tb_dmem_pipe.sv
// Scoreboard bench for dmem_pipe at RD_LAT=2 with a small array: a driver queues
// expected responses, a monitor pops and compares on every response handshake.
module tb_dmem_pipe;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              resp_we;

    logic [33:0] sb [$];
    logic [31:0] model [DEPTH];
    int errors = 0;
    int checks = 0;
    int stalls = 0;

    always #5 clk = ~clk;

    dmem_pipe #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR ('0),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_we    (resp_we)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the request is accepted.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] mask, input logic [31:0] exp_rdata, input logic exp_err);
        int n = 0;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n > 0) stalls++;
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_timeout: req_ready stuck at 0 for addr %0h", addr);
            req_valid = 1'b0;
            return;
        end
        sb.push_back({exp_rdata, exp_err, we});
        if (we && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) model[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_left", 64'(sb.size()), 64'(0));
    endtask

    // Monitor samples one time unit before each rising edge, clear of driver updates.
    initial begin
        logic        held;
        logic [34:0] held_v;
        logic [33:0] exp;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) checkOutput("stall_hold", 64'({resp_valid, resp_rdata, resp_err, resp_we}), 64'(held_v));
                if (resp_valid && resp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_resp: got rdata=%0h err=%0b we=%0b, expected none",
                                 resp_rdata, resp_err, resp_we);
                    end else begin
                        exp = sb.pop_front();
                        checkOutput("resp", 64'({resp_rdata, resp_err, resp_we}), 64'(exp));
                    end
                end
                held   = resp_valid && !resp_ready;
                held_v = {resp_valid, resp_rdata, resp_err, resp_we};
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        int acc;
        logic [31:0] a;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("rst_resp_rdata", 64'(resp_rdata), 64'(0));
        checkOutput("rst_resp_err", 64'(resp_err), 64'(0));
        checkOutput("rst_resp_we", 64'(resp_we), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rst", 64'(req_ready), 64'(1));

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 4'hF, 32'h0, 1'b0);
        waitDrain();

        // Basic write then read, plus isolated read latency
        applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        waitDrain();
        applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        k = 0;
        while (!resp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("read_latency", 64'(k), 64'(RD_LAT));
        waitDrain();

        // Byte-masked merge and back-to-back read-after-write
        applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        applyStimulus(1'b1, 32'h40, 32'h00000055, 4'hF, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 32'h00000055, 1'b0);
        waitDrain();

        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            applyStimulus(1'b0, a, 32'h0, 4'h0, model[a[9:2]], 1'b0);
        end
        checkOutput("throughput_stalls", 64'(stalls), 64'(0));
        waitDrain();

        // Error cases: none of these may touch the array
        applyStimulus(1'b0, 32'h102, 32'h0, 4'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h102, 32'h12345678, 4'hF, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h104, 32'h87654321, 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'(i * 4), 32'h0, 4'h0, model[i], 1'b0);
        waitDrain();

        // Backpressure: responses stalled, admission must stop at RD_LAT+2
        resp_ready = 1'b0;
        acc = 0;
        req_we = 1'b0;
        req_wmask = 4'h0;
        for (int c = 0; c < 10; c++) begin
            req_addr  = 32'((8 + acc) * 4);
            req_valid = 1'b1;
            if (req_ready) begin
                sb.push_back({model[8 + acc], 1'b0, 1'b0});
                acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("bp_accepted", 64'(acc), 64'(RD_LAT + 2));
        checkOutput("bp_req_ready", 64'(req_ready), 64'(0));
        repeat (3) @(negedge clk);
        resp_ready = 1'b1;
        waitDrain();

        // Reset with responses in flight; the final write must still commit
        applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        applyStimulus(1'b1, 32'h44, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("midrst_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("midrst_req_ready", 64'(req_ready), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        applyStimulus(1'b0, 32'h44, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
